// File: rtl/fns_tsv_pkg.sv
// Shared types and constant helpers for the FNS TSV encoder.
package fns_tsv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_READY,
    ST_ENC,
    ST_OUT
  } state_t;

  // Fibonacci number with F(1) = F(2) = 1.
  function automatic int unsigned fib(input int unsigned n);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    a = 1;
    b = 1;
    for (int unsigned i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  // The largest codeword value F(N_TSV+2)-1 has to fit in a data word.
  function automatic bit fns_width_ok(input int unsigned n_tsv, input int unsigned data_w);
    return (fib(n_tsv + 2) - 1) <= ((32'd1 << data_w) - 1);
  endfunction

endpackage

// File: rtl/fns_weight_table.sv
// Fault-map scan: assigns Fibonacci weights to healthy TSVs, one TSV per cycle.
module fns_weight_table
  import fns_tsv_pkg::*;
#(
  parameter int N_TSV  = 9,
  parameter int DATA_W = 7,
  parameter int CNT_W  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           load,
  input  logic                           step,
  input  logic [N_TSV-1:0]               f_flag,
  output logic [N_TSV-1:0][DATA_W-1:0]   weight,
  output logic [DATA_W-1:0]              capacity,
  output logic [N_TSV-1:0]               en_flag,
  output logic [CNT_W-1:0]               fault_cnt,
  output logic                           scan_last
);

  localparam int IDX_W = $clog2(N_TSV);

  logic [N_TSV-1:0]  f_lat;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] w_cur;
  logic [DATA_W-1:0] w_nxt;
  logic [DATA_W-1:0] w_cur_upd;
  logic [CNT_W-1:0]  fault_acc;
  logic              cur_faulty;

  assign cur_faulty = f_lat[idx];
  assign scan_last  = (idx == IDX_W'(N_TSV - 1));
  // Count including the TSV being scanned this cycle, so the FSM can decide on the last step.
  assign fault_cnt  = fault_acc + CNT_W'(cur_faulty);
  // w_cur always holds F(K+2) after K healthy TSVs, hence capacity = w_cur - 1.
  assign w_cur_upd  = cur_faulty ? w_cur : w_nxt;

  // Scan bookkeeping: index, Fibonacci pair, fault count and the end-of-scan results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      f_lat     <= '0;
      idx       <= '0;
      w_cur     <= DATA_W'(1);
      w_nxt     <= DATA_W'(2);
      fault_acc <= '0;
      capacity  <= '0;
      en_flag   <= '0;
    end else if (load) begin
      f_lat     <= f_flag;
      idx       <= '0;
      w_cur     <= DATA_W'(1);
      w_nxt     <= DATA_W'(2);
      fault_acc <= '0;
    end else if (step) begin
      fault_acc <= fault_cnt;
      // w_nxt may wrap past the last healthy TSV; it is never consumed then.
      if (!cur_faulty) begin
        w_cur <= w_nxt;
        w_nxt <= w_cur + w_nxt;
      end
      if (scan_last) begin
        capacity <= w_cur_upd - DATA_W'(1);
        en_flag  <= ~f_lat;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Weight register array, written at the scanned index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      weight <= '0;
    end else if (step && !load) begin
      weight[idx] <= cur_faulty ? '0 : w_cur;
    end
  end

endmodule

// File: rtl/fns_tsv_serial_encoder.sv
// Fault-aware serial Zeckendorf encoder for a TSV bundle with spares.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no valid fault map; waits for a cfg request
// ST_CFG   | weight table scans TSV 0..N_TSV-1, one per cycle
// ST_READY | accepts a data word or a new fault map (cfg wins)
// ST_ENC   | greedy scan from TSV N_TSV-1 down to 0, one per cycle
// ST_OUT   | codeword presented until out_ready
module fns_tsv_serial_encoder
  import fns_tsv_pkg::*;
#(
  parameter int N_TSV   = 9,
  parameter int N_SPARE = 4,
  parameter int DATA_W  = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [N_TSV-1:0]  f_flag,
  output logic              cfg_err,
  output logic [DATA_W-1:0] capacity,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_TSV-1:0]  tsv,
  output logic              out_err,
  output logic [N_TSV-1:0]  en_flag
);

  localparam int CNT_W = $clog2(N_TSV + 1);
  localparam int IDX_W = $clog2(N_TSV);

  if (!fns_width_ok(N_TSV, DATA_W)) begin : g_width_err
    $error("fns_tsv_serial_encoder: DATA_W too narrow for N_TSV");
  end

  state_t                         state;
  state_t                         state_nxt;
  logic [N_TSV-1:0][DATA_W-1:0]   weight;
  logic [CNT_W-1:0]               fault_cnt;
  logic                           scan_last;
  logic [DATA_W-1:0]              residual;
  logic [IDX_W-1:0]               enc_idx;
  logic                           cfg_hs;
  logic                           cfg_fail;
  logic                           over;

  assign cfg_ready = (state == ST_IDLE) || (state == ST_READY);
  assign in_ready  = (state == ST_READY) && !cfg_valid;
  assign cfg_hs    = cfg_valid && cfg_ready;
  assign cfg_fail  = int'(fault_cnt) > N_SPARE;
  assign over      = datain > capacity;

  fns_weight_table #(
    .N_TSV  (N_TSV),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_weights (
    .clock     (clock),
    .reset     (reset),
    .load      (cfg_hs),
    .step      (state == ST_CFG),
    .f_flag    (f_flag),
    .weight    (weight),
    .capacity  (capacity),
    .en_flag   (en_flag),
    .fault_cnt (fault_cnt),
    .scan_last (scan_last)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; cfg_valid outranks in_valid in READY.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cfg_valid) state_nxt = ST_CFG;
      ST_CFG:   if (scan_last) state_nxt = cfg_fail ? ST_IDLE : ST_READY;
      ST_READY: begin
        if (cfg_valid)     state_nxt = ST_CFG;
        else if (in_valid) state_nxt = over ? ST_OUT : ST_ENC;
      end
      ST_ENC:   if (enc_idx == '0) state_nxt = ST_OUT;
      ST_OUT:   if (out_ready) state_nxt = ST_READY;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: config result, word accept, greedy encode and output handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tsv       <= '0;
      residual  <= '0;
      enc_idx   <= '0;
      cfg_err   <= 1'b0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_CFG: if (scan_last) cfg_err <= cfg_fail;
        ST_READY: begin
          if (!cfg_valid && in_valid) begin
            tsv      <= '0;
            residual <= datain;
            enc_idx  <= IDX_W'(N_TSV - 1);
            if (over) begin
              out_err   <= 1'b1;
              out_valid <= 1'b1;
            end
          end
        end
        ST_ENC: begin
          if (en_flag[enc_idx] && (residual >= weight[enc_idx])) begin
            tsv[enc_idx] <= 1'b1;
            residual     <= residual - weight[enc_idx];
          end
          if (enc_idx == '0) out_valid <= 1'b1;
          else               enc_idx   <= enc_idx - IDX_W'(1);
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fns_tsv_serial_encoder.sv
// Randomised self-checking bench for fns_tsv_serial_encoder against a behavioural FNS model.
module tb_fns_tsv_serial_encoder;

  localparam int N_TSV  = 9;
  localparam int DATA_W = 7;

  logic              clock;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [N_TSV-1:0]  f_flag;
  logic              cfg_err;
  logic [DATA_W-1:0] capacity;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] datain;
  logic              out_valid;
  logic              out_ready;
  logic [N_TSV-1:0]  tsv;
  logic              out_err;
  logic [N_TSV-1:0]  en_flag;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int or_mode = 2;  // 0 random, 1 forced low, 2 forced high
  logic [N_TSV-1:0] model_ff = '0;

  typedef struct {
    logic [N_TSV-1:0] tsv;
    logic             err;
    int               t;
    int               lat;
    int               d;
    logic [N_TSV-1:0] ff;
  } exp_t;

  exp_t q[$];
  bit   front_seen = 0;

  fns_tsv_serial_encoder dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .f_flag    (f_flag),
    .cfg_err   (cfg_err),
    .capacity  (capacity),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .datain    (datain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tsv       (tsv),
    .out_err   (out_err),
    .en_flag   (en_flag)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int fibn(input int n);
    int a = 1, b = 1, t;
    for (int i = 3; i <= n; i++) begin t = a + b; a = b; b = t; end
    return b;
  endfunction

  function automatic int model_cap(input logic [N_TSV-1:0] ff);
    return fibn(N_TSV - $countones(ff) + 2) - 1;
  endfunction

  function automatic logic [N_TSV-1:0] model_enc(input logic [N_TSV-1:0] ff, input int d);
    int w[N_TSV];
    int k = 0;
    int r = d;
    logic [N_TSV-1:0] cw = '0;
    for (int i = 0; i < N_TSV; i++) begin
      if (ff[i]) w[i] = 0;
      else begin k++; w[i] = fibn(k + 1); end
    end
    if (d > model_cap(ff)) return '0;
    for (int i = N_TSV - 1; i >= 0; i--)
      if (!ff[i] && r >= w[i]) begin cw[i] = 1'b1; r -= w[i]; end
    return cw;
  endfunction

  // Independent rule check on the DUT codeword: sums to d, no adjacent healthy ones, faulty bits 0.
  function automatic bit zeck_ok(input logic [N_TSV-1:0] ff, input logic [N_TSV-1:0] cw, input int d);
    int w = 1, wn = 2, sum = 0, t;
    bit prev = 0;
    for (int i = 0; i < N_TSV; i++) begin
      if (ff[i]) begin
        if (cw[i]) return 0;
      end else begin
        if (cw[i]) begin
          if (prev) return 0;
          sum += w;
        end
        prev = cw[i];
        t = w + wn; w = wn; wn = t;
      end
    end
    return sum == d;
  endfunction

  // ---------------- out_ready driver ----------------
  initial begin
    out_ready = 0;
    forever begin
      @(posedge clock); #1;
      case (or_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (in_valid && in_ready) begin
          e.d   = int'(datain);
          e.ff  = model_ff;
          e.t   = cyc;
          e.err = (e.d > model_cap(model_ff));
          e.tsv = model_enc(model_ff, e.d);
          e.lat = e.err ? 1 : N_TSV + 1;
          q.push_back(e);
        end
        if (out_valid) begin
          if (q.size() == 0) check("unexpected_out_valid", 1, 0);
          else begin
            if (!front_seen) begin
              check("out_latency", cyc - q[0].t, q[0].lat);
              if (!q[0].err) check("zeckendorf_rules", zeck_ok(q[0].ff, tsv, q[0].d), 1);
              front_seen = 1;
            end
            check("tsv", tsv, q[0].tsv);
            check("out_err", out_err, q[0].err);
            check("in_ready_during_out", in_ready, 0);
            if (out_ready) begin
              void'(q.pop_front());
              front_seen = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic cfg_start(input logic [N_TSV-1:0] ff);
    bit ok = 0;
    @(posedge clock); #1;
    cfg_valid = 1; f_flag = ff;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (cfg_ready) begin ok = 1; break; end
    end
    if (!ok) check("cfg_ready_timeout", 0, 1);
    @(posedge clock); #1;
    cfg_valid = 0;
  endtask

  task automatic cfg_finish(input logic [N_TSV-1:0] ff);
    int n = 0;
    logic [N_TSV-1:0] nf;
    nf = ~ff;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (cfg_ready) begin n = i; break; end
    end
    check("cfg_latency", n, N_TSV + 1);
    check("capacity", capacity, model_cap(ff));
    check("en_flag", en_flag, nf);
    check("cfg_err", cfg_err, ($countones(ff) > 4) ? 1 : 0);
    model_ff = ff;
  endtask

  task automatic do_cfg(input logic [N_TSV-1:0] ff);
    cfg_start(ff);
    cfg_finish(ff);
  endtask

  task automatic send(input int d);
    bit ok = 0;
    @(posedge clock); #1;
    in_valid = 1; datain = DATA_W'(d);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    @(posedge clock); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tsv"}, tsv, 0);
    check({tag, "_en_flag"}, en_flag, 0);
    check({tag, "_capacity"}, capacity, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_out_err"}, out_err, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N_TSV-1:0] ff;
    int n;
    int cap;
    bit ok;
    reset = 1; cfg_valid = 0; f_flag = '0; in_valid = 0; datain = '0;

    // Hand-computed pins on the model itself.
    check("pin_cap_nofault", model_cap(9'b000000000), 88);
    check("pin_enc_88", model_enc(9'b000000000, 88), 9'b101010101);
    check("pin_cap_two_faults", model_cap(9'b110000000), 33);
    check("pin_enc_33", model_enc(9'b110000000, 33), 9'b001010101);
    check("pin_enc_20_tsv1", model_enc(9'b000000010, 20), 9'b001010100);

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    check("reset_cfg_ready", cfg_ready, 1);
    @(posedge clock); #1;
    reset = 0;

    // No faults: full-range values and the overflow boundary.
    or_mode = 2;
    do_cfg(9'b000000000);
    send(88); send(0); send(89); send(1); send(127);
    drain();

    // Two top TSVs faulty.
    do_cfg(9'b110000000);
    send(33); send(34); send(12);
    drain();

    // Hole at TSV1.
    do_cfg(9'b000000010);
    send(20); send(54);
    drain();

    // cfg wins over data in the same READY cycle.
    @(posedge clock); #1;
    cfg_valid = 1; in_valid = 1; f_flag = '0; datain = 7'd10;
    @(negedge clock);
    check("prio_in_ready", in_ready, 0);
    check("prio_cfg_ready", cfg_ready, 1);
    @(posedge clock); #1;
    cfg_valid = 0; in_valid = 0;
    cfg_finish(9'b000000000);

    // Too many faults: back to IDLE, data refused; then recover with four faults.
    do_cfg(9'b000011111);
    in_valid = 1; datain = 7'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("cfg_err_in_ready", in_ready, 0);
    end
    in_valid = 0;
    do_cfg(9'b000001111);
    send(7); send(4);
    drain();

    // Back-pressure: codeword held, no new accept.
    do_cfg(9'b000000000);
    or_mode = 1;
    send(50);
    in_valid = 1; datain = 7'd3;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) check("backpressure_out_valid_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_out_valid", out_valid, 1);
      check("hold_tsv", tsv, model_enc(9'b000000000, 50));
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    or_mode = 2;
    drain();

    // Reset in the middle of an encode.
    send(88);
    repeat (3) @(posedge clock);
    #2 reset = 1;
    #1;
    check_reset_outputs("midenc_reset");
    q.delete();
    front_seen = 0;
    @(posedge clock); #1;
    reset = 0;
    do_cfg(9'b000000000);
    send(88);
    drain();

    // Randomised fault maps, data and back-pressure.
    or_mode = 0;
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 5);
      ff = '0;
      while ($countones(ff) < n) ff[$urandom_range(0, N_TSV - 1)] = 1'b1;
      do_cfg(ff);
      if (n > 4) begin
        ff = '0;
        while ($countones(ff) < 4) ff[$urandom_range(0, N_TSV - 1)] = 1'b1;
        do_cfg(ff);
      end
      cap = model_cap(ff);
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 1) == 0) send($urandom_range(0, cap));
        else send($urandom_range(0, 127));
      end
      drain();
    end

    or_mode = 2;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
